uart_cipher_sequencer: RTL

Sequences the byte stream between the UART core and the Enigma cipher core. Accepts received bytes from the UART, folds letters to uppercase and forwards them to the cipher, then queues ciphered bytes in a small FIFO. It drains the FIFO to the UART transmitter using the UART's transmit/is_transmitting handshake. It also collects link-error statistics for the debug LEDs.

---
 rtl/uart_cipher_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/uart_cipher_sequencer.sv
// uart_cipher_sequencer
// Moves bytes UART rx -> letter fold -> hold register -> cipher core -> output
// FIFO -> UART tx, and keeps sticky/saturating link statistics for the LEDs.
//
// Cipher handshake: a request transfers on every clock edge where ci_valid and
// ci_ready are both high. ci_valid and ci_byte stay high/stable until then.
// Only one byte is ever in flight, and its FIFO slot is reserved up front, so
// the single-cycle co_valid pulse can always be pushed.
module uart_cipher_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TX_ACK_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       received,
  input  logic [7:0] rx_byte,
  input  logic       recv_error,
  input  logic       is_transmitting,
  output logic       transmit,
  output logic [7:0] tx_byte,
  output logic       ci_valid,
  output logic [7:0] ci_byte,
  input  logic       ci_ready,
  input  logic       co_valid,
  input  logic [7:0] co_byte,
  output logic [7:0] drop_count,
  output logic [7:0] rx_err_count,
  output logic       overrun,
  output logic       tx_timeout,
  output logic       busy,
  output logic [1:0] c_state_dbg,
  output logic [1:0] t_state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TX_ACK_TIMEOUT + 1);
  localparam logic [AW:0]   PTR_ONE    = {{AW{1'b0}}, 1'b1};
  localparam logic [TW-1:0] TIMER_ONE  = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] TIMER_LAST = TW'(TX_ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {C_IDLE = 2'd0, C_REQ = 2'd1, C_WAIT = 2'd2} c_state_t;
  typedef enum logic [1:0] {T_IDLE = 2'd0, T_PULSE = 2'd1, T_ACK = 2'd2, T_DONE = 2'd3} t_state_t;

  c_state_t c_state, c_next;
  t_state_t t_state, t_next;

  logic          hold_full, hold_full_d;
  logic [7:0]    hold_data, hold_data_d;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
  logic [TW-1:0] timer;
  logic          fifo_full, fifo_empty;
  logic          is_upper, is_lower, is_letter;
  logic          hs, hold_free, load, drop, ovr, push, pop, ack_expired;
  logic          transmit_d, ci_valid_d, tx_timeout_d, busy_d;
  logic [7:0]    tx_byte_d, ci_byte_d;

  assign c_state_dbg = c_state;
  assign t_state_dbg = t_state;

  // Input classification, hold register and FIFO bookkeeping
  always_comb begin
    is_upper    = (rx_byte >= 8'h41) && (rx_byte <= 8'h5A);
    is_lower    = (rx_byte >= 8'h61) && (rx_byte <= 8'h7A);
    is_letter   = is_upper || is_lower;
    hs          = (c_state == C_REQ) && ci_ready;
    // A clearing handshake frees the hold register for a same-cycle load
    hold_free   = !hold_full || hs;
    load        = received && hold_free && is_letter;
    drop        = received && hold_free && !is_letter;
    ovr         = received && !hold_free;
    hold_full_d = load ? 1'b1 : (hs ? 1'b0 : hold_full);
    hold_data_d = load ? (is_lower ? rx_byte - 8'h20 : rx_byte) : hold_data;
    push        = (c_state == C_WAIT) && co_valid;
    pop         = (t_state == T_PULSE);
    fifo_empty  = (wr_ptr == rd_ptr);
    fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    wr_ptr_d    = push ? wr_ptr + PTR_ONE : wr_ptr;
    rd_ptr_d    = pop ? rd_ptr + PTR_ONE : rd_ptr;
    ack_expired = (t_state == T_ACK) && !is_transmitting && (timer == TIMER_LAST);
  end

  // State registers for both FSMs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_state <= C_IDLE;
      t_state <= T_IDLE;
    end else begin
      c_state <= c_next;
      t_state <= t_next;
    end
  end

  // Cipher FSM next state; entering C_REQ reserves the FIFO slot
  always_comb begin
    c_next = c_state;
    case (c_state)
      C_IDLE:  if (hold_full && !fifo_full) c_next = C_REQ;
      C_REQ:   if (ci_ready) c_next = C_WAIT;
      C_WAIT:  if (co_valid) c_next = C_IDLE;
      default: c_next = C_IDLE;
    endcase
  end

  // TX FSM next state
  always_comb begin
    t_next = t_state;
    case (t_state)
      T_IDLE:  if (!fifo_empty && !is_transmitting) t_next = T_PULSE;
      T_PULSE: t_next = T_ACK;
      T_ACK: begin
        if (is_transmitting) t_next = T_DONE;
        else if (ack_expired) t_next = T_IDLE;
      end
      T_DONE:  if (!is_transmitting) t_next = T_IDLE;
      default: t_next = T_IDLE;
    endcase
  end

  // Output decode: next values for the registered outputs
  always_comb begin
    ci_valid_d   = (c_next == C_REQ);
    ci_byte_d    = ci_byte;
    transmit_d   = (t_next == T_PULSE);
    tx_byte_d    = tx_byte;
    tx_timeout_d = tx_timeout || ack_expired;
    if ((c_state == C_IDLE) && (c_next == C_REQ)) ci_byte_d = hold_data;
    if ((t_state == T_IDLE) && (t_next == T_PULSE)) tx_byte_d = mem[rd_ptr[AW-1:0]];
    busy_d = (c_next != C_IDLE) || (t_next != T_IDLE) || hold_full_d || (wr_ptr_d != rd_ptr_d);
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      transmit   <= 1'b0;
      tx_byte    <= 8'h00;
      ci_valid   <= 1'b0;
      ci_byte    <= 8'h00;
      tx_timeout <= 1'b0;
      busy       <= 1'b0;
    end else begin
      transmit   <= transmit_d;
      tx_byte    <= tx_byte_d;
      ci_valid   <= ci_valid_d;
      ci_byte    <= ci_byte_d;
      tx_timeout <= tx_timeout_d;
      busy       <= busy_d;
    end
  end

  // Hold register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_data <= 8'h00;
    end else begin
      hold_full <= hold_full_d;
      hold_data <= hold_data_d;
    end
  end

  // Link statistics: saturating counters and sticky overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count   <= 8'h00;
      rx_err_count <= 8'h00;
      overrun      <= 1'b0;
    end else begin
      if (drop && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
      if (recv_error && (rx_err_count != 8'hFF)) rx_err_count <= rx_err_count + 8'd1;
      if (ovr) overrun <= 1'b1;
    end
  end

  // FIFO pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_d;
      rd_ptr <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= co_byte;
  end

  // Acknowledge timer, cleared on the transmit pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timer <= '0;
    else if (t_state == T_PULSE) timer <= '0;
    else if (t_state == T_ACK) timer <= timer + TIMER_ONE;
  end

endmodule
